// File: rtl/bp_update_unit_if.sv
// bp_update_unit_if
// Bundles the two buses of the branch-predictor update unit:
//   - the EX-stage resolved-branch bus (ex_*), driven by the pipeline;
//   - the BTB write port (btb_ready from the BTB, btb_wen/index/pc/target to it).
// Modports:
//   master : the pipeline/BTB side (drives ex_* and btb_ready)
//   slave  : bp_update_unit (consumes ex_* and btb_ready, drives btb_* writes)
// Parameter GHR_W is the global history width and BTB index width.
interface bp_update_unit_if #(
  parameter int GHR_W = 8
);
  // Resolved branch from EX
  logic             ex_br_valid;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_hit;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic [GHR_W-1:0] ex_ghr;
  // BTB write port
  logic             btb_ready;
  logic             btb_wen;
  logic [GHR_W-1:0] btb_index_w;
  logic [31:0]      btb_pc_w;
  logic [31:0]      btb_target_w;

  modport master (
    output ex_br_valid, ex_pc, ex_taken, ex_target,
           ex_pred_hit, ex_pred_taken, ex_pred_target, ex_ghr, btb_ready,
    input  btb_wen, btb_index_w, btb_pc_w, btb_target_w
  );

  modport slave (
    input  ex_br_valid, ex_pc, ex_taken, ex_target,
           ex_pred_hit, ex_pred_taken, ex_pred_target, ex_ghr, btb_ready,
    output btb_wen, btb_index_w, btb_pc_w, btb_target_w
  );
endinterface

// File: rtl/bp_update_unit.sv
// bp_update_unit
// Write-side companion of the BTB and gshare predictor. Takes branches
// resolved in EX, raises a registered one-cycle front-end redirect on a
// mispredict (with the repaired history for the fetch GHR), keeps the
// architectural GHR, and queues BTB updates in a small FIFO that drains
// onto the BTB write port one entry per cycle while btb_ready is high.
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   bus (slave)      : ex_* resolved-branch bus and BTB write port
//   redirect_valid/redirect_pc       : registered redirect pulse and pc
//   ghr_fix_valid/ghr_fix            : history repair, paired with redirect
//   ghr_arch         : architectural global history
//   fifo_full        : update queue holds FIFO_DEPTH entries
//   perf_branches/perf_mispred/perf_dropped : event counters
// Build option: define BPU_PERF_CNT_EN to build the 32-bit perf counters;
// without it the perf outputs are tied to zero.
module bp_update_unit #(
  parameter int GHR_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_OFF   = 8
) (
  input  logic              clk,
  input  logic              reset,
  bp_update_unit_if.slave   bus,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [GHR_W-1:0]  ghr_arch,
  output logic              ghr_fix_valid,
  output logic [GHR_W-1:0]  ghr_fix,
  output logic              fifo_full,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred,
  output logic [31:0]       perf_dropped
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  // Update queue storage; read only through the registered btb_* outputs
  logic [GHR_W-1:0] idx_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem  [FIFO_DEPTH];
  logic [31:0]      tgt_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic             redirect_valid_reg;
  logic [31:0]      redirect_pc_reg;
  logic [GHR_W-1:0] ghr_fix_reg, ghr_arch_reg;
  logic             btb_wen_reg;
  logic [GHR_W-1:0] btb_index_reg;
  logic [31:0]      btb_pc_reg, btb_target_reg;

  logic             target_diff, mis, upd, full, pop, push, drop;
  logic [GHR_W-1:0] ghr_next, index_next;
  logic [31:0]      redirect_pc_next;

  always_comb begin
    target_diff = bus.ex_pred_target != bus.ex_target;
    mis  = bus.ex_br_valid &&
           ((bus.ex_pred_taken != bus.ex_taken) ||
            (bus.ex_taken && (!bus.ex_pred_hit || target_diff)));
    upd  = bus.ex_br_valid && (!bus.ex_pred_hit || target_diff);
    full = (count_reg == FULL_CNT);
    pop  = (count_reg != '0) && bus.btb_ready;
    // A full queue still accepts a push when the head leaves on the same edge
    push = upd && (!full || pop);
    drop = upd && full && !pop;
    // History built from the fetch snapshot so back-to-back branches agree
    ghr_next   = {bus.ex_ghr[GHR_W-2:0], bus.ex_taken};
    // Must match the fetch-side BTB read index for the same pc/history
    index_next = bus.ex_pc[GHR_W+1:2] ^ bus.ex_ghr;
    redirect_pc_next = bus.ex_taken ? bus.ex_target
                                    : bus.ex_pc + 32'(SLOT_OFF);
  end

  // Storage has no reset: contents are only meaningful behind the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_reg] <= index_next;
      pc_mem[wr_ptr_reg]  <= bus.ex_pc;
      tgt_mem[wr_ptr_reg] <= bus.ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      ghr_fix_reg        <= '0;
      ghr_arch_reg       <= '0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      btb_wen_reg        <= 1'b0;
      btb_index_reg      <= '0;
      btb_pc_reg         <= '0;
      btb_target_reg     <= '0;
    end else begin
      redirect_valid_reg <= mis;
      if (mis) begin
        redirect_pc_reg <= redirect_pc_next;
        ghr_fix_reg     <= ghr_next;
      end
      if (bus.ex_br_valid) ghr_arch_reg <= ghr_next;

      btb_wen_reg <= pop;
      if (pop) begin
        btb_index_reg  <= idx_mem[rd_ptr_reg];
        btb_pc_reg     <= pc_mem[rd_ptr_reg];
        btb_target_reg <= tgt_mem[rd_ptr_reg];
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign redirect_valid   = redirect_valid_reg;
  assign redirect_pc      = redirect_pc_reg;
  assign ghr_fix_valid    = redirect_valid_reg;
  assign ghr_fix          = ghr_fix_reg;
  assign ghr_arch         = ghr_arch_reg;
  assign fifo_full        = full;
  assign bus.btb_wen      = btb_wen_reg;
  assign bus.btb_index_w  = btb_index_reg;
  assign bus.btb_pc_w     = btb_pc_reg;
  assign bus.btb_target_w = btb_target_reg;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_branches_reg, perf_mispred_reg, perf_dropped_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches_reg <= '0;
      perf_mispred_reg  <= '0;
      perf_dropped_reg  <= '0;
    end else begin
      if (bus.ex_br_valid) perf_branches_reg <= perf_branches_reg + 1'b1;
      if (mis)             perf_mispred_reg  <= perf_mispred_reg + 1'b1;
      if (drop)            perf_dropped_reg  <= perf_dropped_reg + 1'b1;
    end
  end

  assign perf_branches = perf_branches_reg;
  assign perf_mispred  = perf_mispred_reg;
  assign perf_dropped  = perf_dropped_reg;
`else
  // drop only feeds the counters
  logic unused_drop;
  assign unused_drop   = drop;
  assign perf_branches = '0;
  assign perf_mispred  = '0;
  assign perf_dropped  = '0;
`endif
endmodule

// File: tb/tb_bp_update_unit.sv
// tb_bp_update_unit
// Directed and random stimulus for bp_update_unit. Every driven cycle pushes
// the expected outputs of the following edge into a scoreboard queue; a
// monitor pops one entry per clock and compares it with the DUT.
module tb_bp_update_unit;
  localparam int GHR_W = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_update_unit_if #(.GHR_W(GHR_W)) bus ();

  logic              redirect_valid, ghr_fix_valid, fifo_full;
  logic [31:0]       redirect_pc, perf_branches, perf_mispred, perf_dropped;
  logic [GHR_W-1:0]  ghr_arch, ghr_fix;

  bp_update_unit #(.GHR_W(GHR_W), .FIFO_DEPTH(DEPTH), .SLOT_OFF(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ghr_arch       (ghr_arch),
    .ghr_fix_valid  (ghr_fix_valid),
    .ghr_fix        (ghr_fix),
    .fifo_full      (fifo_full),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred),
    .perf_dropped   (perf_dropped)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int wen_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic             rst;
    logic             rv;
    logic [31:0]      rpc;
    logic [GHR_W-1:0] rfix;
    logic [GHR_W-1:0] ghr;
    logic             wen;
    logic [GHR_W-1:0] idx;
    logic [31:0]      wpc;
    logic [31:0]      wtgt;
    logic             full;
    logic [31:0]      pb;
    logic [31:0]      pm;
    logic [31:0]      pd;
  } exp_t;

  typedef struct packed {
    logic [GHR_W-1:0] idx;
    logic [31:0]      pc;
    logic [31:0]      tgt;
  } ent_t;

  exp_t eq[$];
  // Reference model state (owned by the stimulus process only)
  ent_t mq[$];
  logic [GHR_W-1:0] m_ghr = '0;
  logic [31:0] m_pb = '0, m_pm = '0, m_pd = '0;

  // Drive one cycle (called at a falling edge) and record what the next
  // rising edge must produce; returns at the following falling edge.
  task automatic drive(input logic rst, input logic v, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt, input logic hit,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic [GHR_W-1:0] ghr, input logic rdy);
    exp_t e;
    ent_t h, n;
    logic mis, upd, full_b, pop;
    e = '0;
    if (rst) begin
      mq.delete();
      m_ghr = '0;
      m_pb = '0; m_pm = '0; m_pd = '0;
      e.rst = 1'b1;
    end else begin
      mis = v && ((ptk != tk) || (tk && (!hit || ptgt != tgt)));
      upd = v && (!hit || ptgt != tgt);
      full_b = (mq.size() == DEPTH);
      pop = (mq.size() > 0) && rdy;
      if (pop) begin
        h = mq.pop_front();
        e.wen = 1'b1; e.idx = h.idx; e.wpc = h.pc; e.wtgt = h.tgt;
      end
      if (upd) begin
        if (!full_b || pop) begin
          n.idx = pc[GHR_W+1:2] ^ ghr; n.pc = pc; n.tgt = tgt;
          mq.push_back(n);
        end else begin
          m_pd++;
        end
      end
      if (v) begin
        m_ghr = {ghr[GHR_W-2:0], tk};
        m_pb++;
        if (mis) m_pm++;
      end
      e.rv   = mis;
      e.rpc  = tk ? tgt : pc + 32'd8;
      e.rfix = {ghr[GHR_W-2:0], tk};
    end
    e.ghr  = m_ghr;
    e.full = (mq.size() == DEPTH);
`ifdef BPU_PERF_CNT_EN
    e.pb = m_pb; e.pm = m_pm; e.pd = m_pd;
`endif
    eq.push_back(e);
    reset              = rst;
    bus.ex_br_valid    = v;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_hit    = hit;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    bus.ex_ghr         = ghr;
    bus.btb_ready      = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, rdy);
  endtask

  // "Missing" branch: no BTB hit, taken, so it both redirects and updates
  task automatic miss_br(input logic [31:0] pc, input logic [GHR_W-1:0] ghr,
                         input logic rdy);
    drive(1'b0, 1'b1, pc, 1'b1, pc + 32'h100, 1'b0, 1'b1, '0, ghr, rdy);
  endtask

  // Scoreboard monitor: one expected entry per rising edge
  always @(posedge clk) begin : monitor
    exp_t m;
    #1;
    if (bus.btb_wen === 1'b1) wen_cnt++;
    if (eq.size() > 0) begin
      m = eq.pop_front();
      check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, m.rv});
      check_eq("ghr_fix_valid", {31'd0, ghr_fix_valid}, {31'd0, m.rv});
      if (m.rv || m.rst) begin
        check_eq("redirect_pc", redirect_pc, m.rpc);
        check_eq("ghr_fix", 32'(ghr_fix), 32'(m.rfix));
      end
      check_eq("ghr_arch", 32'(ghr_arch), 32'(m.ghr));
      check_eq("btb_wen", {31'd0, bus.btb_wen}, {31'd0, m.wen});
      if (m.wen || m.rst) begin
        check_eq("btb_index_w", 32'(bus.btb_index_w), 32'(m.idx));
        check_eq("btb_pc_w", bus.btb_pc_w, m.wpc);
        check_eq("btb_target_w", bus.btb_target_w, m.wtgt);
      end
      check_eq("fifo_full", {31'd0, fifo_full}, {31'd0, m.full});
      check_eq("perf_branches", perf_branches, m.pb);
      check_eq("perf_mispred", perf_mispred, m.pm);
      check_eq("perf_dropped", perf_dropped, m.pd);
      $display("[TB] cyc t=%0t rv=%0b rpc=%08h ghr=%02h wen=%0b idx=%02h pc_w=%08h full=%0b",
               $time, redirect_valid, redirect_pc, ghr_arch, bus.btb_wen,
               bus.btb_index_w, bus.btb_pc_w, fifo_full);
    end
  end

  initial begin : stim
    int base;
    logic [31:0] pc, tgt, ptgt;
    logic tk, hit, ptk, v, rdy;
    @(negedge clk);
    // Reset held two cycles while a mispredicting branch is presented
    drive(1'b1, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 1'b0, '0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 1'b0, '0, 8'h00, 1'b1);
    idle(1'b1, 2);
    check_eq("empty_after_reset_wen", {31'd0, bus.btb_wen}, 32'd0);

    // Taken branch, BTB miss
    drive(1'b0, 1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 1'b0, '0, 8'h00, 1'b1);
    check_eq("t1_redirect_pc", redirect_pc, 32'h00400100);
    check_eq("t1_ghr_fix", 32'(ghr_fix), 32'h01);
    idle(1'b1, 1);
    check_eq("t1_wen", {31'd0, bus.btb_wen}, 32'd1);
    check_eq("t1_index", 32'(bus.btb_index_w), 32'h04);
    check_eq("t1_pc_w", bus.btb_pc_w, 32'h00400010);
    check_eq("t1_target_w", bus.btb_target_w, 32'h00400100);

    // Predicted taken, actually not taken, target matched: redirect, no write
    drive(1'b0, 1'b1, 32'h00400020, 1'b0, 32'h00400200, 1'b1, 1'b1, 32'h00400200, 8'h01, 1'b1);
    check_eq("t2_redirect_pc", redirect_pc, 32'h00400028);
    idle(1'b1, 1);
    check_eq("t2_no_wen", {31'd0, bus.btb_wen}, 32'd0);

    // Five missing branches with the BTB port busy
    for (int i = 0; i < 5; i++) begin
      miss_br(32'h00401000 + 32'(i * 4), 8'(i * 3), 1'b0);
      if (i == 3) check_eq("fill_full_after_4", {31'd0, fifo_full}, 32'd1);
    end
`ifdef BPU_PERF_CNT_EN
    check_eq("fill_dropped", perf_dropped, 32'd1);
`endif
    base = wen_cnt;
    idle(1'b1, 6);
    check_eq("drain_wen_count", 32'(wen_cnt - base), 32'd4);

    // Full queue, pop and push on the same edge
    for (int i = 0; i < 4; i++) miss_br(32'h00402000 + 32'(i * 4), 8'h10, 1'b0);
    base = wen_cnt;
    miss_br(32'h00403000, 8'h22, 1'b1);
    check_eq("pushpop_full", {31'd0, fifo_full}, 32'd1);
    idle(1'b1, 6);
    check_eq("pushpop_wen_count", 32'(wen_cnt - base), 32'd5);

    // Correctly predicted taken branch
    drive(1'b0, 1'b1, 32'h00400040, 1'b1, 32'h00400300, 1'b1, 1'b1, 32'h00400300, 8'h80, 1'b1);
    check_eq("t5_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("t5_ghr_arch", 32'(ghr_arch), 32'h01);
    idle(1'b1, 1);
    check_eq("t5_no_wen", {31'd0, bus.btb_wen}, 32'd0);

    // Reset mid-operation discards queued updates and a pending redirect
    miss_br(32'h00404000, 8'h05, 1'b0);
    miss_br(32'h00404004, 8'h06, 1'b0);
    drive(1'b1, 1'b1, 32'h00404008, 1'b1, 32'h00404100, 1'b0, 1'b0, '0, 8'h07, 1'b0);
    base = wen_cnt;
    idle(1'b1, 3);
    check_eq("midreset_no_wen", 32'(wen_cnt - base), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      v    = 1'($urandom_range(0, 1));
      pc   = {20'h00400, 10'($urandom), 2'b00};
      tk   = 1'($urandom_range(0, 1));
      tgt  = {20'h00410, 10'($urandom), 2'b00};
      hit  = 1'($urandom_range(0, 1));
      ptk  = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 1) ? tgt : tgt + 32'h4;
      rdy  = ($urandom_range(0, 3) != 0);
      drive(1'b0, v, pc, tk, tgt, hit, ptk, ptgt, 8'($urandom), rdy);
    end
    idle(1'b1, 6);

    check_eq("scoreboard_drained", 32'(eq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
